gin_mcast_buffered: RTL and testbench
=====================================

# gin_mcast_buffered

Parametrised successor to the global input network (GIN). It takes tagged packets `{row_tag, col_tag, data}` through a valid/ready port and buffers them in a FIFO. Each packet is multicast to every PE whose scan-programmed row and column IDs match its tags. Delivery is partial and persistent: ready targets are served at once, and busy targets are retried until every target has taken the packet. Adds an all-ones wildcard tag, drop accounting for unmatched packets, and safe reprogramming while traffic is queued. Sits between the global buffer and the PE array.

## Interface
- BITWIDTH, 16, data word width
- TAG_LENGTH, 10, row/col tag and ID width
- X_BUS_SIZE, 4, PEs per row (columns)
- Y_BUS_SIZE, 4, rows
- FIFO_DEPTH, 4, input packet FIFO entries (power of 2, ≥2)
- DROP_CNT_WIDTH, 8, drop counter width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- program  in  1  scan-programming enable
- scan_tag_in  in  TAG_LENGTH  serial ID word, shifted once per cycle while program=1
- in_valid  in  1  packet offered
- in_ready  out  1  packet accepted when in_valid & in_ready at an edge
- in_packet  in  2*TAG_LENGTH+BITWIDTH  {row_tag, col_tag, data}, MSB first
- pe_enable  out  NUM_PE  per-PE write strobe, NUM_PE=X_BUS_SIZE*Y_BUS_SIZE
- pe_ready  in  NUM_PE  per-PE can-accept
- pe_value  out  BITWIDTH*NUM_PE  data to each PE; slice i = bits [i*BITWIDTH +: BITWIDTH]
- busy  out  1  FIFO non-empty or delivery in progress
- drop_count  out  DROP_CNT_WIDTH  packets discarded for matching no PE, saturating

## Operation
- ID chain: N = Y_BUS_SIZE + NUM_PE registers id[0..N-1].
  - While program=1: id[N-1] <= scan_tag_in and id[k] <= id[k+1] each cycle.
  - After N shifts, the first word shifted in sits in id[0].
  - id[r], r < Y_BUS_SIZE, is the row ID of row r.
  - id[Y_BUS_SIZE + r*X_BUS_SIZE + c] is the column ID of PE(r,c).
  - PE index i = r*X_BUS_SIZE + c.
- Match for PE(r,c): (row_tag==id[r] or row_tag all-ones) and (col_tag==id[col(r,c)] or col_tag all-ones).
- in_ready = !fifo_full & !program & !rst. A push never happens while the FIFO is full, even if a pop occurs in the same cycle.
- Delivery register holds data_q and pending[NUM_PE].
  - pe_enable[i] = pending[i] & pe_ready[i], combinational.
  - Every pe_value slice = data_q whenever pending != 0; otherwise 0.
  - At each edge: pending <= pending & ~pe_ready.
- Load condition: delivery is free when (pending & ~pe_ready)==0, and FIFO non-empty, and program=0. When all three hold:
  - Pop the head and compute its match mask.
  - Mask non-zero: pending <= mask, data_q <= head data.
  - Mask zero: packet discarded, drop_count += 1 (holds at max), delivery register stays empty.
  - At most one pop per cycle.
- program=1 blocks new loads. A delivery already in flight completes using its latched mask. Queued packets are matched against the new IDs after program returns to 0.
- busy = fifo non-empty | (pending != 0).

## Timing
- Reset values: in_ready 0, pe_enable 0, pe_value 0, busy 0, drop_count 0. All id registers 0, FIFO empty, pending 0. rst asserted mid-delivery aborts the delivery and empties the FIFO immediately.
- Latency with idle block:
  - Packet accepted at edge T; loaded at edge T+1; pe_enable high during the cycle after T+1 for all ready targets.
  - Back-to-back packets whose targets are all ready: one packet delivered per cycle.
- A busy target keeps pe_enable low and pending set. It receives the packet in the first cycle its pe_ready is high, with no cycle of gap.
- A dropped packet consumes one pop cycle.
- Full FIFO: in_ready drops the cycle after the edge that filled it, and rises the cycle after a pop.

## Test plan
- Reset/program: hold rst, check all outputs 0. Release rst; program=1 for 20 cycles shifting IDs 0,1,2,3 | 0,1,2,3 | 1,2,3,4 | 2,3,4,5 | 3,4,5,6 → id[] equals that list in order.
- Unicast: pe_ready all 1; send row=1, col=2, data=9 at edge T → only pe_enable[5] high, in the cycle after T+1; pe_value[5] = 9; busy falls afterwards.
- Wildcard: row=all-ones, col=3, data=0x00AB → pe_enable high on exactly PEs 3, 6, 9, 12 in the same cycle.
- Partial delivery: same wildcard packet with pe_ready[9]=0 for 3 cycles → PEs 3, 6, 12 served first. PE 9 is served on its first ready cycle. The next queued packet is not loaded until then.
- Drop and backpressure:
  - Send row=7, col=0 → no enable; drop_count = 1.
  - With pe_ready=0 and one unicast to PE 0 in flight, push 5 more unicasts → in_ready goes 0 after FIFO_DEPTH=4 further packets.
  - Release pe_ready → all packets delivered in order.
- Reprogram with queued traffic: raise program while 2 packets are queued → in_ready 0, no loads. Reprogram row 1 ID to 9. A queued row=9 packet then hits row 1.

Source files
------------

// File: rtl/gin_mcast_buffered.sv
// gin_mcast_buffered
// Global input network with an input packet FIFO and persistent multicast
// delivery. Tagged packets {row_tag, col_tag, data} are queued, matched
// against scan-programmed row/column IDs (all-ones tag is a wildcard), and
// delivered to every matching PE. Ready targets are served at once and busy
// targets are retried until all have taken the packet. Packets matching no
// PE are discarded and counted.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   program_en      scan-programming enable ("program" is a reserved word)
//   scan_tag_in     serial ID word, shifted once per cycle while program_en=1
//   in_valid        packet offered
//   in_ready        packet accepted on in_valid & in_ready at an edge
//   in_packet       {row_tag, col_tag, data}, MSB first
//   pe_enable       per-PE write strobe (pending & pe_ready)
//   pe_ready        per-PE can-accept
//   pe_value        packet data, replicated into every PE slice
//   busy            FIFO non-empty or delivery in progress
//   drop_count      saturating count of packets that matched no PE
module gin_mcast_buffered #(
   parameter int unsigned BITWIDTH       = 16,
   parameter int unsigned TAG_LENGTH     = 10,
   parameter int unsigned X_BUS_SIZE     = 4,
   parameter int unsigned Y_BUS_SIZE     = 4,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned DROP_CNT_WIDTH = 8
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       program_en,
   input  logic [TAG_LENGTH-1:0]                      scan_tag_in,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic [2*TAG_LENGTH+BITWIDTH-1:0]           in_packet,
   output logic [X_BUS_SIZE*Y_BUS_SIZE-1:0]           pe_enable,
   input  logic [X_BUS_SIZE*Y_BUS_SIZE-1:0]           pe_ready,
   output logic [BITWIDTH*X_BUS_SIZE*Y_BUS_SIZE-1:0]  pe_value,
   output logic                                       busy,
   output logic [DROP_CNT_WIDTH-1:0]                  drop_count
);

   localparam int unsigned NUM_PE = X_BUS_SIZE * Y_BUS_SIZE;
   localparam int unsigned N_ID   = Y_BUS_SIZE + NUM_PE;
   localparam int unsigned PKT_W  = 2 * TAG_LENGTH + BITWIDTH;
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = PTR_W + 1;

   // ID scan chain: rows first, then column IDs of every PE in row-major order
   logic [TAG_LENGTH-1:0]     id_q [N_ID];
   logic [TAG_LENGTH-1:0]     id_d [N_ID];

   // Input packet FIFO
   logic [PKT_W-1:0]          mem_q [FIFO_DEPTH];
   logic [PKT_W-1:0]          mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]          count_q, count_d;

   // Delivery register
   logic [NUM_PE-1:0]         pending_q, pending_d;
   logic [BITWIDTH-1:0]       data_q, data_d;
   logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;

   logic                      fifo_full_c;
   logic                      fifo_empty_c;
   logic                      push_c;
   logic                      pop_c;
   logic                      stall_c;
   logic [PKT_W-1:0]          head_c;
   logic [TAG_LENGTH-1:0]     head_row_c;
   logic [TAG_LENGTH-1:0]     head_col_c;
   logic [BITWIDTH-1:0]       head_data_c;
   logic [NUM_PE-1:0]         match_c;

   // FIFO status and handshake
   assign fifo_full_c  = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty_c = (count_q == '0);
   assign in_ready     = !fifo_full_c && !program_en && !rst;
   assign push_c       = in_valid && in_ready;

   // Delivery is free once no target is left that cannot take the packet this cycle
   assign stall_c      = |(pending_q & ~pe_ready);
   assign pop_c        = !stall_c && !fifo_empty_c && !program_en;

   // Head-of-queue packet fields
   assign head_c       = mem_q[rd_ptr_q];
   assign head_row_c   = head_c[PKT_W-1 -: TAG_LENGTH];
   assign head_col_c   = head_c[TAG_LENGTH+BITWIDTH-1 -: TAG_LENGTH];
   assign head_data_c  = head_c[BITWIDTH-1:0];

   // Multicast match mask for the head packet; all-ones tag matches any ID
   always_comb begin
      match_c = '0;
      for (int unsigned r = 0; r < Y_BUS_SIZE; r++) begin
         for (int unsigned c = 0; c < X_BUS_SIZE; c++) begin
            match_c[r*X_BUS_SIZE + c] =
               ((head_row_c == id_q[r]) || (&head_row_c)) &&
               ((head_col_c == id_q[Y_BUS_SIZE + r*X_BUS_SIZE + c]) || (&head_col_c));
         end
      end
   end

   // ID chain shift: new word enters at the top and walks towards id[0]
   always_comb begin
      id_d = id_q;
      if (program_en) begin
         for (int unsigned k = 0; k < N_ID - 1; k++) begin
            id_d[k] = id_q[k+1];
         end
         id_d[N_ID-1] = scan_tag_in;
      end
   end

   // FIFO next state
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_c) begin
         mem_d[wr_ptr_q] = in_packet;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
   end

   // Delivery next state: served targets clear, a pop either loads or drops
   always_comb begin
      pending_d    = pending_q & ~pe_ready;
      data_d       = data_q;
      drop_count_d = drop_count_q;
      if (pop_c) begin
         if (|match_c) begin
            pending_d = match_c;
            data_d    = head_data_c;
         end else if (drop_count_q != '1) begin
            drop_count_d = drop_count_q + DROP_CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < N_ID; k++) begin
            id_q[k] <= '0;
         end
         for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
            mem_q[k] <= '0;
         end
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         pending_q    <= '0;
         data_q       <= '0;
         drop_count_q <= '0;
      end else begin
         id_q         <= id_d;
         mem_q        <= mem_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         pending_q    <= pending_d;
         data_q       <= data_d;
         drop_count_q <= drop_count_d;
      end
   end

   // Outputs
   assign pe_enable  = pending_q & pe_ready;
   assign busy       = !fifo_empty_c || (|pending_q);
   assign drop_count = drop_count_q;

   for (genvar g = 0; g < NUM_PE; g++) begin : g_pe_value
      assign pe_value[g*BITWIDTH +: BITWIDTH] = (|pending_q) ? data_q : '0;
   end

endmodule

// File: tb/tb_gin_mcast_buffered.sv
// Directed testbench for gin_mcast_buffered. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_gin_mcast_buffered;

   localparam int unsigned BW     = 16;
   localparam int unsigned TL     = 10;
   localparam int unsigned NUM_PE = 16;
   localparam int unsigned PKT_W  = 2*TL + BW;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   program_en;
   logic [TL-1:0]          scan_tag_in;
   logic                   in_valid;
   logic                   in_ready;
   logic [PKT_W-1:0]       in_packet;
   logic [NUM_PE-1:0]      pe_enable;
   logic [NUM_PE-1:0]      pe_ready;
   logic [BW*NUM_PE-1:0]   pe_value;
   logic                   busy;
   logic [7:0]             drop_count;

   int checks = 0;
   int passed = 0;

   logic [TL-1:0] ids  [20] = '{0,1,2,3, 0,1,2,3, 1,2,3,4, 2,3,4,5, 3,4,5,6};
   logic [TL-1:0] ids2 [20] = '{0,9,2,3, 0,1,2,3, 1,2,3,4, 2,3,4,5, 3,4,5,6};

   gin_mcast_buffered dut (
      .clk         (clk),
      .rst         (rst),
      .program_en  (program_en),
      .scan_tag_in (scan_tag_in),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_packet   (in_packet),
      .pe_enable   (pe_enable),
      .pe_ready    (pe_ready),
      .pe_value    (pe_value),
      .busy        (busy),
      .drop_count  (drop_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one packet and wait (bounded) until it is accepted
   task automatic push_pkt(input logic [TL-1:0] row, input logic [TL-1:0] col,
                           input logic [BW-1:0] data);
      bit ok = 1'b0;
      in_valid  = 1'b1;
      in_packet = {row, col, data};
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (!ok) $display("FAIL push_accept: packet %h not accepted within 50 cycles", {row, col, data});
      else passed++;
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else passed++;
      checks++; if (pe_enable !== '0) $display("FAIL rst_pe_enable: got %h want 0", pe_enable); else passed++;
      checks++; if (pe_value !== '0) $display("FAIL rst_pe_value: got %h want 0", pe_value); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
      checks++; if (drop_count !== 8'd0) $display("FAIL rst_drop_count: got %0d want 0", drop_count); else passed++;
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_program();
      program_en = 1'b1;
      for (int k = 0; k < 20; k++) begin
         scan_tag_in = ids[k];
         if (k == 0) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b0) $display("FAIL prog_in_ready: got %b want 0", in_ready); else passed++;
         end
         tick();
      end
      program_en = 1'b0;
      for (int k = 0; k < 20; k++) begin
         checks++;
         if (dut.id_q[k] !== ids[k]) $display("FAIL prog_id[%0d]: got %0d want %0d", k, dut.id_q[k], ids[k]);
         else passed++;
      end
   endtask

   task automatic test_unicast();
      pe_ready = '1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) $display("FAIL uni_in_ready: got %b want 1", in_ready); else passed++;
      tick();
      push_pkt(10'd1, 10'd2, 16'd9);
      @(negedge clk);
      checks++; if (pe_enable !== 16'h0000) $display("FAIL uni_early_en: got %h want 0000", pe_enable); else passed++;
      checks++; if (busy !== 1'b1) $display("FAIL uni_busy: got %b want 1", busy); else passed++;
      tick();
      @(negedge clk);
      checks++; if (pe_enable !== 16'h0020) $display("FAIL uni_en: got %h want 0020", pe_enable); else passed++;
      checks++; if (pe_value[5*BW +: BW] !== 16'd9) $display("FAIL uni_val5: got %h want 0009", pe_value[5*BW +: BW]); else passed++;
      checks++; if (pe_value !== {16{16'h0009}}) $display("FAIL uni_val_all: got %h", pe_value); else passed++;
      tick();
      @(negedge clk);
      checks++; if (pe_enable !== 16'h0000) $display("FAIL uni_en_after: got %h want 0000", pe_enable); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL uni_busy_after: got %b want 0", busy); else passed++;
      checks++; if (pe_value !== '0) $display("FAIL uni_val_after: got %h want 0", pe_value); else passed++;
      tick();
   endtask

   task automatic test_wildcard();
      push_pkt(10'h3FF, 10'd3, 16'h00AB);
      tick();
      @(negedge clk);
      checks++; if (pe_enable !== 16'h1248) $display("FAIL wild_en: got %h want 1248", pe_enable); else passed++;
      checks++; if (pe_value[3*BW +: BW] !== 16'h00AB) $display("FAIL wild_val3: got %h want 00ab", pe_value[3*BW +: BW]); else passed++;
      tick();
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL wild_busy_after: got %b want 0", busy); else passed++;
      tick();
   endtask

   task automatic test_partial();
      pe_ready = ~16'h0200;
      push_pkt(10'h3FF, 10'd3, 16'h00AB);
      push_pkt(10'd1, 10'd2, 16'h0055);
      @(negedge clk);
      checks++; if (pe_enable !== 16'h1048) $display("FAIL part_first_en: got %h want 1048", pe_enable); else passed++;
      tick();
      @(negedge clk);
      checks++; if (pe_enable !== 16'h0000) $display("FAIL part_wait1_en: got %h want 0000", pe_enable); else passed++;
      checks++; if (busy !== 1'b1) $display("FAIL part_wait1_busy: got %b want 1", busy); else passed++;
      tick();
      @(negedge clk);
      checks++; if (pe_enable !== 16'h0000) $display("FAIL part_wait2_en: got %h want 0000", pe_enable); else passed++;
      tick();
      pe_ready = '1;
      @(negedge clk);
      checks++; if (pe_enable !== 16'h0200) $display("FAIL part_pe9_en: got %h want 0200", pe_enable); else passed++;
      checks++; if (pe_value[9*BW +: BW] !== 16'h00AB) $display("FAIL part_pe9_val: got %h want 00ab", pe_value[9*BW +: BW]); else passed++;
      tick();
      @(negedge clk);
      checks++; if (pe_enable !== 16'h0020) $display("FAIL part_next_en: got %h want 0020", pe_enable); else passed++;
      checks++; if (pe_value[5*BW +: BW] !== 16'h0055) $display("FAIL part_next_val: got %h want 0055", pe_value[5*BW +: BW]); else passed++;
      tick();
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL part_busy_after: got %b want 0", busy); else passed++;
      tick();
   endtask

   task automatic test_drop();
      push_pkt(10'd7, 10'd0, 16'h0077);
      tick();
      @(negedge clk);
      checks++; if (pe_enable !== 16'h0000) $display("FAIL drop_en: got %h want 0000", pe_enable); else passed++;
      checks++; if (drop_count !== 8'd1) $display("FAIL drop_count: got %0d want 1", drop_count); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b want 0", busy); else passed++;
      tick();
   endtask

   task automatic test_backpressure();
      logic [BW-1:0] got [8];
      int  n = 0;
      bit  stray = 1'b0;
      bit  accept;
      pe_ready = '0;
      for (int i = 0; i < 5; i++) push_pkt(10'd0, 10'd0, BW'(16'h0100 + i));
      in_valid  = 1'b1;
      in_packet = {10'd0, 10'd0, 16'h0105};
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", in_ready); else passed++;
      checks++; if (pe_enable !== 16'h0000) $display("FAIL bp_blocked_en: got %h want 0000", pe_enable); else passed++;
      tick();
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready2: got %b want 0", in_ready); else passed++;
      tick();
      pe_ready = '1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (cyc == 0) begin
            checks++; if (in_ready !== 1'b0) $display("FAIL bp_ready_c0: got %b want 0", in_ready); else passed++;
         end
         if (cyc == 1) begin
            checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_c1: got %b want 1", in_ready); else passed++;
         end
         if ((pe_enable & ~16'h0001) != '0) stray = 1'b1;
         if (pe_enable[0] && n < 8) begin
            got[n] = pe_value[BW-1:0];
            n++;
         end
         accept = in_valid && in_ready;
         tick();
         if (accept) in_valid = 1'b0;
      end
      checks++; if (n !== 6) $display("FAIL bp_deliv_count: got %0d want 6", n); else passed++;
      checks++; if (stray !== 1'b0) $display("FAIL bp_stray_en: got %b want 0", stray); else passed++;
      for (int i = 0; i < 6 && i < n; i++) begin
         checks++;
         if (got[i] !== BW'(16'h0100 + i)) $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], BW'(16'h0100 + i));
         else passed++;
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL bp_busy_after: got %b want 0", busy); else passed++;
      tick();
   endtask

   task automatic test_reprogram();
      pe_ready = '0;
      push_pkt(10'd0, 10'd0, 16'h0200);
      push_pkt(10'd9, 10'd2, 16'h0300);
      push_pkt(10'd1, 10'd2, 16'h0301);
      program_en = 1'b1;
      for (int k = 0; k < 20; k++) begin
         scan_tag_in = ids2[k];
         if (k == 1) pe_ready = '1;
         @(negedge clk);
         if (k == 0) begin
            checks++; if (in_ready !== 1'b0) $display("FAIL reprog_in_ready: got %b want 0", in_ready); else passed++;
            checks++; if (busy !== 1'b1) $display("FAIL reprog_busy: got %b want 1", busy); else passed++;
         end
         if (k == 1) begin
            checks++; if (pe_enable !== 16'h0001) $display("FAIL reprog_inflight_en: got %h want 0001", pe_enable); else passed++;
            checks++; if (pe_value[BW-1:0] !== 16'h0200) $display("FAIL reprog_inflight_val: got %h want 0200", pe_value[BW-1:0]); else passed++;
         end
         if (k == 2) begin
            checks++; if (pe_enable !== 16'h0000) $display("FAIL reprog_noload_en: got %h want 0000", pe_enable); else passed++;
            checks++; if (busy !== 1'b1) $display("FAIL reprog_noload_busy: got %b want 1", busy); else passed++;
         end
         tick();
      end
      program_en = 1'b0;
      checks++; if (dut.id_q[1] !== 10'd9) $display("FAIL reprog_id1: got %0d want 9", dut.id_q[1]); else passed++;
      @(negedge clk);
      checks++; if (pe_enable !== 16'h0000) $display("FAIL reprog_load_wait: got %h want 0000", pe_enable); else passed++;
      tick();
      @(negedge clk);
      checks++; if (pe_enable !== 16'h0020) $display("FAIL reprog_hit_en: got %h want 0020", pe_enable); else passed++;
      checks++; if (pe_value[5*BW +: BW] !== 16'h0300) $display("FAIL reprog_hit_val: got %h want 0300", pe_value[5*BW +: BW]); else passed++;
      tick();
      @(negedge clk);
      checks++; if (pe_enable !== 16'h0000) $display("FAIL reprog_old_en: got %h want 0000", pe_enable); else passed++;
      checks++; if (drop_count !== 8'd2) $display("FAIL reprog_drop: got %0d want 2", drop_count); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reprog_busy_after: got %b want 0", busy); else passed++;
      tick();
   endtask

   task automatic test_reset_mid();
      pe_ready = '0;
      push_pkt(10'd2, 10'd2, 16'h0400);
      push_pkt(10'd2, 10'd2, 16'h0401);
      @(negedge clk);
      checks++; if (busy !== 1'b1) $display("FAIL rmid_busy_before: got %b want 1", busy); else passed++;
      tick();
      rst      = 1'b1;
      pe_ready = '1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else passed++;
      checks++; if (pe_enable !== 16'h0000) $display("FAIL rmid_en: got %h want 0000", pe_enable); else passed++;
      checks++; if (pe_value !== '0) $display("FAIL rmid_val: got %h want 0", pe_value); else passed++;
      checks++; if (drop_count !== 8'd0) $display("FAIL rmid_drop: got %0d want 0", drop_count); else passed++;
      checks++; if (in_ready !== 1'b0) $display("FAIL rmid_in_ready: got %b want 0", in_ready); else passed++;
      tick();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL rmid_busy_release: got %b want 0", busy); else passed++;
      checks++; if (in_ready !== 1'b1) $display("FAIL rmid_ready_release: got %b want 1", in_ready); else passed++;
      tick();
   endtask

   initial begin
      rst         = 1'b1;
      program_en  = 1'b0;
      scan_tag_in = '0;
      in_valid    = 1'b0;
      in_packet   = '0;
      pe_ready    = '1;
      test_reset();
      test_program();
      test_unicast();
      test_wildcard();
      test_partial();
      test_drop();
      test_backpressure();
      test_reprogram();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
